conv_ctrl_param: RTL and testbench

- Parametrised convolution-layer controller. Successor to the fixed single-channel 5x5 / 10x10 conv controllers.
- Walks kernel column, kernel row, input channel, output column, output row and output channel.
- Emits weight and feature read addresses, accumulator-clear, output write address and write-enable, and a done pulse. All outputs are aligned to the shared MAC/adder/bias/ReLU datapath by configurable delay lines.
- Adds a stride, multi-channel accumulation, a step-enable stall input, and a busy flag.

---
 rtl/conv_ctrl_param.sv | 175 +++++++++++++++++
 tb/tb_conv_ctrl_param.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_ctrl_param.sv
// Parametrised convolution-layer controller: walks kernel/channel/output loops and emits
// read addresses, accumulator clear, output write strobe and done, aligned by delay lines.
module conv_ctrl_param #(
  parameter int unsigned K        = 5,
  parameter int unsigned IN_W     = 14,
  parameter int unsigned IN_H     = 14,
  parameter int unsigned STRIDE   = 1,
  parameter int unsigned C_IN     = 6,
  parameter int unsigned C_OUT    = 16,
  parameter int unsigned ADDR_LAT = 3,
  parameter int unsigned CLR_DLY  = 6,
  parameter int unsigned WR_DLY   = 13,
  localparam int unsigned OUT_W   = (IN_W - K) / STRIDE + 1,
  localparam int unsigned OUT_H   = (IN_H - K) / STRIDE + 1,
  localparam int unsigned FA_W    = (C_IN * IN_H * IN_W > 1) ? $clog2(C_IN * IN_H * IN_W) : 1,
  localparam int unsigned WA_W    = (C_OUT * C_IN * K * K > 1) ? $clog2(C_OUT * C_IN * K * K) : 1,
  localparam int unsigned OA_W    = (C_OUT * OUT_H * OUT_W > 1) ? $clog2(C_OUT * OUT_H * OUT_W) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            conv_start,
  input  logic            step_en,
  output logic [WA_W-1:0] w_raddr,
  output logic [FA_W-1:0] f_raddr,
  output logic            rd_vld,
  output logic            acc_clr,
  output logic [OA_W-1:0] o_waddr,
  output logic            o_wr_en,
  output logic            busy,
  output logic            conv_done
);

  localparam int unsigned KW  = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned CIW = (C_IN > 1) ? $clog2(C_IN) : 1;
  localparam int unsigned OXW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int unsigned OYW = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int unsigned COW = (C_OUT > 1) ? $clog2(C_OUT) : 1;

  typedef enum logic [2:0] {
    StIdle  = 3'b001,
    StRun   = 3'b010,
    StDrain = 3'b100
  } state_e;

  state_e state_q, state_d;

  logic [KW-1:0]  kx_q, ky_q;
  logic [CIW-1:0] ci_q;
  logic [OXW-1:0] ox_q;
  logic [OYW-1:0] oy_q;
  logic [COW-1:0] co_q;

  logic kx_t, ky_t, ci_t, ox_t, oy_t, co_t;
  logic step, last_step, clr_flag, wr_flag;
  logic [FA_W-1:0] f_addr;
  logic [WA_W-1:0] w_addr;
  logic [OA_W-1:0] o_addr;

  logic [ADDR_LAT-1:0] vld_p;
  logic [WA_W-1:0]     w_p [ADDR_LAT];
  logic [FA_W-1:0]     f_p [ADDR_LAT];
  logic [CLR_DLY-1:0]  clr_p;
  logic [WR_DLY-1:0]   wr_p, done_p;
  logic [OA_W-1:0]     oa_p [WR_DLY];

  assign kx_t = (kx_q == KW'(K - 1));
  assign ky_t = (ky_q == KW'(K - 1));
  assign ci_t = (ci_q == CIW'(C_IN - 1));
  assign ox_t = (ox_q == OXW'(OUT_W - 1));
  assign oy_t = (oy_q == OYW'(OUT_H - 1));
  assign co_t = (co_q == COW'(C_OUT - 1));

  assign step      = (state_q == StRun) && step_en;
  assign last_step = kx_t && ky_t && ci_t && ox_t && oy_t && co_t;
  assign clr_flag  = step && (kx_q == '0) && (ky_q == '0) && (ci_q == '0);
  assign wr_flag   = step && kx_t && ky_t && ci_t;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (conv_start) state_d = StRun;
      StRun:   if (step && last_step) state_d = StDrain;
      StDrain: if (conv_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Odometer: each counter moves only when every inner counter is at terminal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kx_q <= '0;
      ky_q <= '0;
      ci_q <= '0;
      ox_q <= '0;
      oy_q <= '0;
      co_q <= '0;
    end else if (step) begin
      kx_q <= kx_t ? '0 : kx_q + 1'b1;
      if (kx_t) ky_q <= ky_t ? '0 : ky_q + 1'b1;
      if (kx_t && ky_t) ci_q <= ci_t ? '0 : ci_q + 1'b1;
      if (kx_t && ky_t && ci_t) ox_q <= ox_t ? '0 : ox_q + 1'b1;
      if (kx_t && ky_t && ci_t && ox_t) oy_q <= oy_t ? '0 : oy_q + 1'b1;
      if (kx_t && ky_t && ci_t && ox_t && oy_t) co_q <= co_t ? '0 : co_q + 1'b1;
    end
  end

  // Modular arithmetic in the target width is exact because every result fits it.
  always_comb begin
    f_addr = FA_W'(ci_q) * FA_W'(IN_H * IN_W)
           + (FA_W'(oy_q) * FA_W'(STRIDE) + FA_W'(ky_q)) * FA_W'(IN_W)
           + FA_W'(ox_q) * FA_W'(STRIDE) + FA_W'(kx_q);
    w_addr = ((WA_W'(co_q) * WA_W'(C_IN) + WA_W'(ci_q)) * WA_W'(K) + WA_W'(ky_q)) * WA_W'(K)
           + WA_W'(kx_q);
    o_addr = OA_W'(co_q) * OA_W'(OUT_H * OUT_W) + OA_W'(oy_q) * OA_W'(OUT_W) + OA_W'(ox_q);
  end

  // Address stages load only behind a valid flag so the outputs hold across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
      for (int i = 0; i < int'(ADDR_LAT); i++) begin
        w_p[i] <= '0;
        f_p[i] <= '0;
      end
    end else begin
      vld_p[0] <= step;
      if (step) begin
        w_p[0] <= w_addr;
        f_p[0] <= f_addr;
      end
      for (int i = 1; i < int'(ADDR_LAT); i++) begin
        vld_p[i] <= vld_p[i-1];
        if (vld_p[i-1]) begin
          w_p[i] <= w_p[i-1];
          f_p[i] <= f_p[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_p  <= '0;
      wr_p   <= '0;
      done_p <= '0;
      for (int i = 0; i < int'(WR_DLY); i++) oa_p[i] <= '0;
    end else begin
      clr_p[0]  <= clr_flag;
      wr_p[0]   <= wr_flag;
      done_p[0] <= step && last_step;
      oa_p[0]   <= o_addr;
      for (int i = 1; i < int'(CLR_DLY); i++) clr_p[i] <= clr_p[i-1];
      for (int i = 1; i < int'(WR_DLY); i++) begin
        wr_p[i]   <= wr_p[i-1];
        done_p[i] <= done_p[i-1];
        oa_p[i]   <= oa_p[i-1];
      end
    end
  end

  assign w_raddr   = w_p[ADDR_LAT-1];
  assign f_raddr   = f_p[ADDR_LAT-1];
  assign rd_vld    = vld_p[ADDR_LAT-1];
  assign acc_clr   = clr_p[CLR_DLY-1];
  assign o_wr_en   = wr_p[WR_DLY-1];
  assign o_waddr   = oa_p[WR_DLY-1];
  assign conv_done = done_p[WR_DLY-1];
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_conv_ctrl_param.sv
// Scoreboard bench: a small-stride multi-channel instance plus a K=1, C_IN=1 instance.
module tb_conv_ctrl_param;

  localparam int unsigned K = 2, IN_W = 4, IN_H = 4, STRIDE = 2, C_IN = 2, C_OUT = 2;
  localparam int unsigned ADDR_LAT = 3, CLR_DLY = 6, WR_DLY = 13;
  localparam int unsigned OUT_W = 2, OUT_H = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start_a = 1'b0, step_en_a = 1'b1;
  logic [3:0] w_a;
  logic [4:0] f_a;
  logic [2:0] oa_a;
  logic       rd_a, clr_a, wr_a, busy_a, done_a;

  logic       start_b = 1'b0, step_en_b = 1'b1;
  logic [0:0] w_b;
  logic [3:0] f_b;
  logic [4:0] oa_b;
  logic       rd_b, clr_b, wr_b, busy_b, done_b;

  conv_ctrl_param #(
    .K(K), .IN_W(IN_W), .IN_H(IN_H), .STRIDE(STRIDE), .C_IN(C_IN), .C_OUT(C_OUT),
    .ADDR_LAT(ADDR_LAT), .CLR_DLY(CLR_DLY), .WR_DLY(WR_DLY)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .conv_start(start_a), .step_en(step_en_a),
    .w_raddr(w_a), .f_raddr(f_a), .rd_vld(rd_a), .acc_clr(clr_a),
    .o_waddr(oa_a), .o_wr_en(wr_a), .busy(busy_a), .conv_done(done_a)
  );

  conv_ctrl_param #(
    .K(1), .IN_W(3), .IN_H(3), .STRIDE(1), .C_IN(1), .C_OUT(2),
    .ADDR_LAT(3), .CLR_DLY(6), .WR_DLY(13)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .conv_start(start_b), .step_en(step_en_b),
    .w_raddr(w_b), .f_raddr(f_b), .rd_vld(rd_b), .acc_clr(clr_b),
    .o_waddr(oa_b), .o_wr_en(wr_b), .busy(busy_b), .conv_done(done_b)
  );

  int     checks = 0, errors = 0;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {int w; int f; bit clr; bit wr; int oa; bit last;} rd_t;
  typedef struct {longint due; int oa; bit last;} wr_t;

  rd_t    exp_rd[$];
  longint clr_due[$];
  wr_t    wr_due[$];
  int     rd_idx = 0;
  int     hand_f[8] = '{0, 1, 4, 5, 16, 17, 20, 21};
  rd_t    mon_e;
  wr_t    mon_w, new_w;

  function automatic void push_run_a();
    rd_t e;
    for (int co = 0; co < int'(C_OUT); co++)
      for (int oy = 0; oy < int'(OUT_H); oy++)
        for (int ox = 0; ox < int'(OUT_W); ox++)
          for (int ci = 0; ci < int'(C_IN); ci++)
            for (int ky = 0; ky < int'(K); ky++)
              for (int kx = 0; kx < int'(K); kx++) begin
                e.f    = ci * IN_H * IN_W + (oy * STRIDE + ky) * IN_W + ox * STRIDE + kx;
                e.w    = ((co * C_IN + ci) * K + ky) * K + kx;
                e.clr  = (kx == 0) && (ky == 0) && (ci == 0);
                e.wr   = (kx == K - 1) && (ky == K - 1) && (ci == C_IN - 1);
                e.oa   = co * OUT_H * OUT_W + oy * OUT_W + ox;
                e.last = e.wr && (co == C_OUT - 1) && (oy == OUT_H - 1) && (ox == OUT_W - 1);
                exp_rd.push_back(e);
              end
  endfunction

  // Monitor A: reads are checked in order; clr/write timing is derived from each read.
  always @(negedge clk) if (rst_n) begin
    if (rd_a) begin
      if (exp_rd.size() == 0) chk("unexpected_rd_vld", 1, 0);
      else begin
        mon_e = exp_rd.pop_front();
        chk("w_raddr", w_a, mon_e.w);
        chk("f_raddr", f_a, mon_e.f);
        chk("busy_during_run", busy_a, 1);
        if (rd_idx < 8) chk("hand_f_raddr", f_a, hand_f[rd_idx]);
        if (rd_idx == 8) chk("pixel_ox1_f_start", f_a, 2);
        if (rd_idx == 32) chk("co1_w_start", w_a, 8);
        rd_idx++;
        if (mon_e.clr) clr_due.push_back(cyc + CLR_DLY - ADDR_LAT);
        if (mon_e.wr) begin
          new_w.due  = cyc + WR_DLY - ADDR_LAT;
          new_w.oa   = mon_e.oa;
          new_w.last = mon_e.last;
          wr_due.push_back(new_w);
        end
      end
    end
    if (clr_a) begin
      if (clr_due.size() == 0) chk("unexpected_acc_clr", 1, 0);
      else chk("acc_clr_time", cyc, clr_due.pop_front());
    end
    if (wr_a) begin
      if (wr_due.size() == 0) chk("unexpected_o_wr_en", 1, 0);
      else begin
        mon_w = wr_due.pop_front();
        chk("o_wr_en_time", cyc, mon_w.due);
        chk("o_waddr", oa_a, mon_w.oa);
        chk("conv_done_with_last_wr", done_a, mon_w.last);
      end
    end else if (done_a) chk("conv_done_without_wr", 1, 0);
  end

  // Monitor B: every pixel clears then writes, WR_DLY-CLR_DLY cycles apart.
  longint clr_b_q[$];
  int     b_pix = 0;
  always @(negedge clk) if (rst_n) begin
    if (clr_b) clr_b_q.push_back(cyc);
    if (wr_b) begin
      if (clr_b_q.size() == 0) chk("b_wr_without_clr", 1, 0);
      else chk("b_clr_to_wr_gap", cyc - clr_b_q.pop_front(), 7);
      chk("b_o_waddr", oa_b, b_pix);
      chk("b_done_on_last", done_b, (b_pix == 17) ? 1 : 0);
      b_pix++;
    end else if (done_b) chk("b_done_without_wr", 1, 0);
  end

  bit toggle = 1'b0;
  always @(posedge clk) begin
    #1;
    if (toggle) step_en_a = ~step_en_a;
    else        step_en_a = 1'b1;
  end

  task automatic start_run_a();
    push_run_a();
    rd_idx = 0;
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_a) begin
        seen = 1'b1;
        break;
      end
    end
    chk("conv_done_within_budget", seen, 1);
  endtask

  task automatic check_idle_a(input string tag);
    @(posedge clk); #1;
    chk({tag, "_busy_low"}, busy_a, 0);
    chk({tag, "_rd_queue_empty"}, exp_rd.size(), 0);
    chk({tag, "_clr_queue_empty"}, clr_due.size(), 0);
    chk({tag, "_wr_queue_empty"}, wr_due.size(), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_w_raddr"}, w_a, 0);
    chk({tag, "_f_raddr"}, f_a, 0);
    chk({tag, "_rd_vld"}, rd_a, 0);
    chk({tag, "_acc_clr"}, clr_a, 0);
    chk({tag, "_o_waddr"}, oa_a, 0);
    chk({tag, "_o_wr_en"}, wr_a, 0);
    chk({tag, "_busy"}, busy_a, 0);
    chk({tag, "_conv_done"}, done_a, 0);
  endtask

  initial begin
    int dones;
    bit seen;
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1 check_outputs_zero("after_reset");

    // Unstalled run.
    start_run_a();
    wait_done_a(200);
    check_idle_a("run1");

    // Stalled run with a stray start while busy, then back-to-back restart.
    toggle = 1'b1;
    start_run_a();
    repeat (20) @(posedge clk);
    #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    wait_done_a(400);
    toggle = 1'b0;
    push_run_a();
    rd_idx = 0;
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    wait_done_a(200);
    check_idle_a("run3");

    // K=1, C_IN=1 instance.
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done_b) begin
        seen = 1'b1;
        break;
      end
    end
    chk("b_done_within_budget", seen, 1);
    @(posedge clk); #1;
    chk("b_pixel_count", b_pix, 18);
    chk("b_clr_queue_empty", clr_b_q.size(), 0);
    chk("b_busy_low", busy_b, 0);

    // Reset mid-run: asynchronous clear, no done, clean replay afterwards.
    start_run_a();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rd_idx >= 30) break;
    end
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("mid_reset");
    exp_rd.delete();
    clr_due.delete();
    wr_due.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_a) dones++;
    end
    chk("no_done_after_abort", dones, 0);
    chk("busy_low_after_abort", busy_a, 0);
    start_run_a();
    wait_done_a(200);
    check_idle_a("replay");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
